// File: rtl/ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control unit: ALU codes, opcodes,
// pc_src selects, FSM states, instruction classes and the decode record.
package ctrl_fsm_pkg;

    // ALU operation codes (consumed by the ALU on alu_op)
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    // Opcodes, instr[15:12]
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Highest R-type funct that maps onto an ALU code
    localparam logic [2:0] FUNCT_MAX = 3'd5;

    // Next-PC source select
    localparam logic [1:0] PC_PLUS1  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_HALT   = 3'd5
    } instr_class_t;

    // What the FSM needs to know about the latched instruction
    typedef struct packed {
        logic [3:0]   alu_op;
        logic         alu_src_imm;
        instr_class_t cls;
        logic         illegal;
    } dec_t;

    // R-type funct values 0..5 are ALU operations; 6 and 7 are reserved
    function automatic logic funct_legal(input logic [2:0] funct);
        return funct <= FUNCT_MAX;
    endfunction

endpackage

// File: rtl/ctrl_fsm_decode.sv
// ctrl_decode: purely combinational opcode/funct decoder. Produces the ALU
// code, operand-b select, instruction class and illegal flag.
module ctrl_decode
    import ctrl_fsm_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    output dec_t       dec
);

    // Map opcode/funct onto the decode record; unknown encodings flag illegal
    always_comb begin
        dec.alu_op      = ALU_ADD;
        dec.alu_src_imm = 1'b0;
        dec.cls         = CLS_ALU;
        dec.illegal     = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                if (funct_legal(funct)) begin
                    dec.alu_op = {1'b0, funct};
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_ADDI: begin
                dec.alu_src_imm = 1'b1;
            end
            OP_LW: begin
                dec.alu_src_imm = 1'b1;
                dec.cls         = CLS_LOAD;
            end
            OP_SW: begin
                dec.alu_src_imm = 1'b1;
                dec.cls         = CLS_STORE;
            end
            OP_BEQ: begin
                dec.alu_op = ALU_SUB;
                dec.cls    = CLS_BRANCH;
            end
            OP_JMP: begin
                dec.cls = CLS_JUMP;
            end
            OP_HALT: begin
                dec.cls = CLS_HALT;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control unit for the 16-bit CPU. Steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath,
// ALU and memory strobes.
// Build option: define CTRL_ILLEGAL_TRAP_EN to trap on illegal encodings
// (TRAP state, illegal_op=1); otherwise they execute as NOPs.
module ctrl_fsm
    import ctrl_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic        ir_load,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        halted,
    output logic        illegal_op
);

    state_t     state_q, state_d;
    logic [3:0] opcode_q;
    logic [2:0] funct_q;
    logic       run_q;
    dec_t       dec;

    // Only opcode and funct are needed here; the rest belongs to the datapath
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[11:3];

    ctrl_decode u_decode (
        .opcode (opcode_q),
        .funct  (funct_q),
        .dec    (dec)
    );

    // Release flag: holds IDLE for one extra edge after reset deasserts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State register plus opcode/funct latched alongside the IR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load) begin
                opcode_q <= instr[15:12];
                funct_q  <= instr[2:0];
            end
        end
    end

    // Next-state and strobes; Moore except fetch completion and BEQ pc_en
    always_comb begin
        state_d      = state_q;
        alu_op       = ALU_ADD;
        alu_src_imm  = 1'b0;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        pc_src       = PC_PLUS1;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;
        halted       = 1'b0;
        illegal_op   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run_q) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec.cls == CLS_HALT) begin
                    state_d = S_HALT;
                end else if (dec.illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op      = dec.alu_op;
                alu_src_imm = dec.alu_src_imm;
                unique case (dec.cls)
                    CLS_ALU:             state_d = S_WB;
                    CLS_LOAD, CLS_STORE: state_d = S_MEM;
                    CLS_BRANCH: begin
                        if (zero) begin
                            pc_en  = 1'b1;
                            pc_src = PC_BRANCH;
                        end
                        state_d = S_FETCH;
                    end
                    CLS_JUMP: begin
                        pc_en   = 1'b1;
                        pc_src  = PC_JUMP;
                        state_d = S_FETCH;
                    end
                    default:             state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                // Address computation stays on the ALU for the whole access
                alu_op       = dec.alu_op;
                alu_src_imm  = dec.alu_src_imm;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (dec.cls == CLS_STORE);
                if (mem_ready) begin
                    state_d = (dec.cls == CLS_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (dec.cls == CLS_LOAD);
                state_d = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_op = 1'b1;
                halted     = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: directed vector table, hand-written corner sequences
// and random instruction streams, all checked cycle by cycle against a
// per-instruction step-list reference model.
module tb_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic [3:0]  alu_op;
    logic        alu_src_imm, ir_load, pc_en, mem_req, mem_we, mem_addr_sel;
    logic        reg_we, wb_sel, halted, illegal_op;
    logic [1:0]  pc_src;

    ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .zero(zero),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .ir_load(ir_load), .pc_en(pc_en),
        .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .halted(halted), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    wire [16:0] act = {alu_op, alu_src_imm, ir_load, pc_en, pc_src, mem_req, mem_we,
                       mem_addr_sel, reg_we, wb_sel, halted, illegal_op};

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instruction is expanded into the list of cycles the spec describes.
    localparam logic [2:0] K_PLAIN = 3'd0;  // one cycle, advance
    localparam logic [2:0] K_FETCH = 3'd1;  // wait for ready, ir_load/pc_en on ready
    localparam logic [2:0] K_MEMW  = 3'd2;  // wait for ready
    localparam logic [2:0] K_BEQ   = 3'd3;  // pc_en/pc_src=1 when zero
    localparam logic [2:0] K_ABS   = 3'd4;  // absorbing until reset
    localparam logic [2:0] K_JMP   = 3'd5;  // pc_en with pc_src=2

    typedef struct packed {
        logic [2:0] kind;
        logic [3:0] alu;
        logic imm, req, we, asel, regwe, wbsel, halt, ill;
    } step_t;

    step_t q[$];

    function automatic step_t mk(input logic [2:0] kind, input logic [3:0] alu, input logic imm,
                                 input logic req, input logic we, input logic asel, input logic regwe,
                                 input logic wbsel, input logic halt, input logic ill);
        step_t s;
        s.kind = kind; s.alu = alu; s.imm = imm; s.req = req; s.we = we; s.asel = asel;
        s.regwe = regwe; s.wbsel = wbsel; s.halt = halt; s.ill = ill;
        return s;
    endfunction

    function automatic step_t s_fetch();
        return mk(K_FETCH, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic step_t s_idle();
        return mk(K_PLAIN, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void push_instr(input logic [15:0] ins);
        logic [3:0] op = ins[15:12];
        logic [2:0] f  = ins[2:0];
        bit illegal = 1'b0;
        q.push_back(s_idle());  // decode cycle: no strobes
        case (op)
            4'h0: if (f <= 3'd5) begin
                q.push_back(mk(K_PLAIN, {1'b0, f}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                q.push_back(mk(K_PLAIN, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                q.push_back(s_fetch());
            end else illegal = 1'b1;
            4'h1: begin
                q.push_back(mk(K_PLAIN, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                q.push_back(mk(K_PLAIN, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                q.push_back(s_fetch());
            end
            4'h2: begin
                q.push_back(mk(K_PLAIN, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                q.push_back(mk(K_MEMW,  4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
                q.push_back(mk(K_PLAIN, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
                q.push_back(s_fetch());
            end
            4'h3: begin
                q.push_back(mk(K_PLAIN, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                q.push_back(mk(K_MEMW,  4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
                q.push_back(s_fetch());
            end
            4'h4: begin
                q.push_back(mk(K_BEQ, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                q.push_back(s_fetch());
            end
            4'h5: begin
                q.push_back(mk(K_JMP, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                q.push_back(s_fetch());
            end
            4'hF: q.push_back(mk(K_ABS, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            q.push_back(mk(K_ABS, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
`else
            q.push_back(s_fetch());
`endif
        end
    endfunction

    function automatic logic [16:0] expect_vec(input step_t s, input logic rdy, input logic z);
        logic       ir, pcen;
        logic [1:0] psrc;
        ir   = (s.kind == K_FETCH) && rdy;
        pcen = ir || ((s.kind == K_BEQ) && z) || (s.kind == K_JMP);
        psrc = ((s.kind == K_BEQ) && z) ? 2'd1 : (s.kind == K_JMP) ? 2'd2 : 2'd0;
        return {s.alu, s.imm, ir, pcen, psrc, s.req, s.we, s.asel, s.regwe, s.wbsel, s.halt, s.ill};
    endfunction

    // Compare this cycle against the model, then advance the model by one edge
    task automatic step_cycle();
        step_t s;
        if (q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL model_empty: no expected step at t=%0t", $time);
        end else begin
            s = q[0];
            chk($sformatf("cycle_outputs{alu,imm,ir,pcen,psrc,req,we,asel,rwe,wbs,hlt,ill} instr=%h", instr),
                act, expect_vec(s, mem_ready, zero));
            if (!(s.kind == K_ABS || ((s.kind == K_FETCH || s.kind == K_MEMW) && !mem_ready))) begin
                void'(q.pop_front());
                if (s.kind == K_FETCH) push_instr(instr);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Assert reset now (asynchronously), check outputs, release and wait for FETCH
    task automatic do_reset();
        int n = 0;
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("reset_outputs_zero", act, 17'd0);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(s_idle());
        q.push_back(s_idle());
        q.push_back(s_fetch());
        while (!mem_req && n < 10) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            step_cycle();
            n++;
        end
        chk("reset_recovery_cycles", n, 2);
    endtask

    // Run one instruction starting in its first FETCH cycle (at a negedge)
    task automatic run_instr(input logic [15:0] ins, input logic z, input int fw, input int mw,
                             input int budget, output int cpi, output int alu_exec,
                             output int n_regwe, output int n_wbsel, output int n_memwe,
                             output int n_pcen, output int n_req, output int pcsrc_max);
        int  cyc = 0, fc = 0, mc = 0, ir_cyc = -100;
        bit  prev = 1'b0, inf;
        cpi = -1; alu_exec = -1; n_regwe = 0; n_wbsel = 0; n_memwe = 0;
        n_pcen = 0; n_req = 0; pcsrc_max = 0;
        instr = ins;
        zero  = z;
        while (cyc < budget) begin
            inf = mem_req && !mem_addr_sel;
            if (cyc > 0 && inf && !prev) begin
                cpi = cyc;
                break;
            end
            prev = inf;
            if (inf) begin
                mem_ready = (fc >= fw); fc++;
            end else if (mem_req) begin
                mem_ready = (mc >= mw); mc++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));  // must be ignored
            end
            #1;
            if (ir_load) ir_cyc = cyc;
            if (cyc == ir_cyc + 2) alu_exec = int'(alu_op);
            n_regwe += int'(reg_we);
            n_wbsel += int'(wb_sel);
            n_memwe += int'(mem_we);
            n_req   += int'(mem_req);
            if (pc_en) begin
                n_pcen++;
                if (int'(pc_src) > pcsrc_max) pcsrc_max = int'(pc_src);
            end
            step_cycle();
            cyc++;
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic        z;
        int fw, mw, cpi, alu, regwe, wbsel, memwe, pcen, req, pcsrc;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int cpi, alu_e, rwe, wbs, mwe, pce, req, psrc;
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cpi, alu_e, rwe, wbs, mwe, pce, req, psrc;
        //            instr     z  fw mw cpi alu rwe wbs mwe pcen req psrc
        tbl.push_back('{16'h0250, 0, 0, 0, 4, 0, 1, 0, 0, 1, 1, 0});
        tbl.push_back('{16'h0251, 0, 2, 0, 6, 1, 1, 0, 0, 1, 3, 0});
        tbl.push_back('{16'h0F05, 0, 0, 0, 4, 5, 1, 0, 0, 1, 1, 0});
        tbl.push_back('{16'h0A64, 1, 0, 0, 4, 4, 1, 0, 0, 1, 1, 0});
        tbl.push_back('{16'h1FFF, 0, 0, 0, 4, 0, 1, 0, 0, 1, 1, 0});
        tbl.push_back('{16'h2285, 0, 0, 3, 8, 0, 1, 1, 0, 1, 5, 0});
        tbl.push_back('{16'h2001, 0, 1, 0, 6, 0, 1, 1, 0, 1, 3, 0});
        tbl.push_back('{16'h3000, 0, 0, 2, 6, 0, 0, 0, 3, 1, 4, 0});
        tbl.push_back('{16'h4000, 1, 0, 0, 3, 1, 0, 0, 0, 2, 1, 1});
        tbl.push_back('{16'h4000, 0, 0, 0, 3, 1, 0, 0, 0, 1, 1, 0});
        tbl.push_back('{16'h5ABC, 0, 0, 0, 3, 0, 0, 0, 0, 2, 1, 2});

        @(negedge clk);
        do_reset();

        // Directed vectors
        foreach (tbl[i]) begin
            run_instr(tbl[i].instr, tbl[i].z, tbl[i].fw, tbl[i].mw, 40,
                      cpi, alu_e, rwe, wbs, mwe, pce, req, psrc);
            chk($sformatf("v%0d_cpi", i),       cpi,   tbl[i].cpi);
            chk($sformatf("v%0d_exec_alu", i),  alu_e, tbl[i].alu);
            chk($sformatf("v%0d_reg_we", i),    rwe,   tbl[i].regwe);
            chk($sformatf("v%0d_wb_sel", i),    wbs,   tbl[i].wbsel);
            chk($sformatf("v%0d_mem_we", i),    mwe,   tbl[i].memwe);
            chk($sformatf("v%0d_pc_en", i),     pce,   tbl[i].pcen);
            chk($sformatf("v%0d_mem_req", i),   req,   tbl[i].req);
            chk($sformatf("v%0d_pc_src", i),    psrc,  tbl[i].pcsrc);
        end

        // SW then HALT: one write, then halted with no further requests
        run_instr(16'h3000, 0, 0, 0, 40, cpi, alu_e, rwe, wbs, mwe, pce, req, psrc);
        chk("sw_write_cycles", mwe, 1);
        run_instr(16'hF000, 0, 0, 0, 23, cpi, alu_e, rwe, wbs, mwe, pce, req, psrc);
        chk("halt_no_next_fetch", cpi, 32'hFFFF_FFFF);
        chk("halt_only_own_fetch_req", req, 1);
        chk("halt_flag", halted, 1);
        do_reset();

        // Illegal opcode and illegal funct
        run_instr(16'h7000, 0, 0, 0, 12, cpi, alu_e, rwe, wbs, mwe, pce, req, psrc);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("illop_trap_no_fetch", cpi, 32'hFFFF_FFFF);
        chk("illop_trap_flags", {illegal_op, halted}, 2'b11);
        do_reset();
`else
        chk("illop_nop_cpi", cpi, 2);
        chk("illop_nop_reg_we", rwe, 0);
        chk("illop_flag_low", illegal_op, 0);
`endif
        run_instr(16'h0007, 0, 0, 0, 12, cpi, alu_e, rwe, wbs, mwe, pce, req, psrc);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("illfunct_trap_no_fetch", cpi, 32'hFFFF_FFFF);
        chk("illfunct_trap_flags", {illegal_op, halted}, 2'b11);
        do_reset();
`else
        chk("illfunct_nop_cpi", cpi, 2);
        chk("illfunct_nop_reg_we", rwe, 0);
`endif

        // Reset asserted mid-MEM aborts the load immediately
        instr = 16'h2285; zero = 1'b0;
        mem_ready = 1'b1; #1; step_cycle();   // FETCH
        mem_ready = 1'b0; #1; step_cycle();   // DECODE
        #1; step_cycle();                     // EXEC
        #1;
        chk("in_mem_before_reset", {mem_req, mem_addr_sel}, 2'b11);
        step_cycle();                         // MEM, still waiting
        #3;
        do_reset();

        // Random instruction stream
        for (int i = 0; i < 150; i++) begin
            int r = $urandom_range(0, 19);
            logic [15:0] ins = 16'($urandom);
            if (r <= 3 || r == 19)  ins = {4'h0, ins[11:3], 3'($urandom_range(0, 5))};
            else if (r == 4)        ins = {4'h0, ins[11:3], 3'($urandom_range(6, 7))};
            else if (r <= 6)        ins[15:12] = 4'h1;
            else if (r <= 9)        ins[15:12] = 4'h2;
            else if (r <= 11)       ins[15:12] = 4'h3;
            else if (r <= 14)       ins[15:12] = 4'h4;
            else if (r <= 16)       ins[15:12] = 4'h5;
            else if (r == 17)       ins[15:12] = 4'($urandom_range(6, 14));
            else                    ins[15:12] = 4'hF;
            run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), 40,
                      cpi, alu_e, rwe, wbs, mwe, pce, req, psrc);
            if (cpi < 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
